// File: rtl/mesi_snoop_bus.sv
// Shared MESI coherence bus: round-robin arbitration of miss/upgrade requests,
// snoop broadcast to the other caches, and write-back/read sequencing to memory.
module mesi_snoop_bus #(
    parameter int unsigned N_CACHES = 4,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CACHES-1:0]        req_valid,
    input  logic [2*N_CACHES-1:0]      req_op,
    input  logic [ADDR_W*N_CACHES-1:0] req_addr,
    input  logic [2*N_CACHES-1:0]      cache_state,
    output logic [N_CACHES-1:0]        gnt,
    output logic [N_CACHES-1:0]        snoop_read,
    output logic [N_CACHES-1:0]        snoop_read_excl,
    output logic [N_CACHES-1:0]        snoop_invalidate,
    output logic [N_CACHES-1:0]        shared_hit,
    output logic [N_CACHES-1:0]        done,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic                       mem_req,
    output logic                       mem_we,
    input  logic                       mem_ack
);

    localparam int unsigned ID_W = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_RDX  = 2'b01;
    localparam logic [1:0] OP_UPGR = 2'b10;
    localparam logic [1:0] ST_I    = 2'b00;
    localparam logic [1:0] ST_M    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_WB, S_MEM, S_DONE} state_t;

    state_t              state, state_d;
    logic [ID_W-1:0]     winner, winner_d, rr_ptr, rr_ptr_d, sel;
    logic [1:0]          op, op_d;
    logic [ADDR_W-1:0]   bus_addr_d;
    logic [N_CACHES-1:0] gnt_d, snoop_read_d, snoop_read_excl_d, snoop_invalidate_d;
    logic [N_CACHES-1:0] shared_hit_d, done_d, win_oh, win_oh_d;
    logic                mem_req_d, mem_we_d, found, shared, dirty;
    int unsigned         idx;

    logic [1:0]          op_arr   [N_CACHES];
    logic [ADDR_W-1:0]   addr_arr [N_CACHES];
    logic [N_CACHES-1:0] line_valid, line_dirty;

    // Unpack the flat per-cache buses into indexable fields
    for (genvar g = 0; g < N_CACHES; g++) begin : g_unpack
        assign op_arr[g]     = req_op[2*g +: 2];
        assign addr_arr[g]   = req_addr[ADDR_W*g +: ADDR_W];
        assign line_valid[g] = (cache_state[2*g +: 2] != ST_I);
        assign line_dirty[g] = (cache_state[2*g +: 2] == ST_M);
    end

    // Snoop response considers only the non-winning caches
    assign win_oh = N_CACHES'(1) << winner;
    assign shared = |(line_valid & ~win_oh);
    assign dirty  = |(line_dirty & ~win_oh);

    always_comb begin
        state_d      = state;
        winner_d     = winner;
        op_d         = op;
        rr_ptr_d     = rr_ptr;
        bus_addr_d   = bus_addr;
        shared_hit_d = shared_hit;
        found        = 1'b0;
        idx          = 0;
        sel          = '0;

        unique case (state)
            S_IDLE: begin
                for (int unsigned k = 0; k < N_CACHES; k++) begin
                    idx = (32'(rr_ptr) + k) % N_CACHES;
                    sel = ID_W'(idx);
                    if (!found && req_valid[sel]) begin
                        found      = 1'b1;
                        winner_d   = sel;
                        op_d       = (op_arr[sel] == 2'b11) ? OP_RD : op_arr[sel];
                        bus_addr_d = addr_arr[sel];
                    end
                end
                if (found) state_d = S_SNOOP;
            end
            S_SNOOP: begin
                shared_hit_d = shared ? win_oh : '0;
                if (dirty)               state_d = S_WB;
                else if (op == OP_UPGR)  state_d = S_DONE;
                else                     state_d = S_MEM;
            end
            S_WB: begin
                if (mem_ack) state_d = (op == OP_UPGR) ? S_DONE : S_MEM;
            end
            S_MEM: begin
                if (mem_ack) state_d = S_DONE;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                rr_ptr_d = (winner == ID_W'(N_CACHES - 1)) ? '0 : winner + ID_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state calls for
        win_oh_d           = N_CACHES'(1) << winner_d;
        gnt_d              = (state_d == S_IDLE) ? '0 : win_oh_d;
        snoop_read_d       = (state_d == S_SNOOP && op_d == OP_RD)   ? ~win_oh_d : '0;
        snoop_read_excl_d  = (state_d == S_SNOOP && op_d == OP_RDX)  ? ~win_oh_d : '0;
        snoop_invalidate_d = (state_d == S_SNOOP && op_d == OP_UPGR) ? ~win_oh_d : '0;
        mem_req_d          = (state_d == S_WB) || (state_d == S_MEM);
        mem_we_d           = (state_d == S_WB);
        done_d             = (state_d == S_DONE) ? win_oh_d : '0;
        if (state_d == S_IDLE) shared_hit_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            winner           <= '0;
            op               <= OP_RD;
            rr_ptr           <= '0;
            bus_addr         <= '0;
            gnt              <= '0;
            snoop_read       <= '0;
            snoop_read_excl  <= '0;
            snoop_invalidate <= '0;
            shared_hit       <= '0;
            done             <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
        end else begin
            state            <= state_d;
            winner           <= winner_d;
            op               <= op_d;
            rr_ptr           <= rr_ptr_d;
            bus_addr         <= bus_addr_d;
            gnt              <= gnt_d;
            snoop_read       <= snoop_read_d;
            snoop_read_excl  <= snoop_read_excl_d;
            snoop_invalidate <= snoop_invalidate_d;
            shared_hit       <= shared_hit_d;
            done             <= done_d;
            mem_req          <= mem_req_d;
            mem_we           <= mem_we_d;
        end
    end

endmodule

// File: tb/tb_mesi_snoop_bus.sv
// Bench for mesi_snoop_bus: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration, snooping and memory phases.
module tb_mesi_snoop_bus;

    localparam int N = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [2*N-1:0] req_op;
    logic [AW*N-1:0] req_addr;
    logic [2*N-1:0] cache_state;
    logic          mem_ack;
    logic [N-1:0]  gnt, snoop_read, snoop_read_excl, snoop_invalidate, shared_hit, done;
    logic [AW-1:0] bus_addr;
    logic          mem_req, mem_we;

    int n_assert = 0;
    int n_fail   = 0;
    int rr       = 0;

    mesi_snoop_bus #(.N_CACHES(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .cache_state(cache_state),
        .gnt(gnt), .snoop_read(snoop_read), .snoop_read_excl(snoop_read_excl),
        .snoop_invalidate(snoop_invalidate), .shared_hit(shared_hit), .done(done),
        .bus_addr(bus_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        return N'(1) << w;
    endfunction

    // Round-robin reference: first requester at or above the pointer, wrapping
    function automatic int pick(input logic [N-1:0] rv, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (rv[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] o, input logic [AW-1:0] a);
        req_valid[i]         = 1'b1;
        req_op[2*i +: 2]     = o;
        req_addr[AW*i +: AW] = a;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_shared"}, 32'(shared_hit), 32'd0);
        chk({tag, "_memreq"}, 32'(mem_req), 32'd0);
    endtask

    // Called with the DUT idle and requests presented; ends in the following IDLE cycle
    task automatic run_txn(input int w, input bit keep, input bit scramble);
        logic [1:0]    o;
        logic [AW-1:0] a;
        logic [N-1:0]  oth, exp_sh;
        bit            sh, dt;
        int            lat;
        o   = req_op[2*w +: 2];
        if (o == 2'b11) o = 2'b00;
        a   = req_addr[AW*w +: AW];
        oth = ~onehot(w);
        sh  = 1'b0;
        dt  = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            if (i != w && cache_state[2*i +: 2] != 2'b00) sh = 1'b1;
            if (i != w && cache_state[2*i +: 2] == 2'b11) dt = 1'b1;
        end
        exp_sh = sh ? onehot(w) : '0;
        chk("snoop_gnt", 32'(gnt), 32'(onehot(w)));
        chk("snoop_rd", 32'(snoop_read), 32'((o == 2'b00) ? oth : '0));
        chk("snoop_rdx", 32'(snoop_read_excl), 32'((o == 2'b01) ? oth : '0));
        chk("snoop_inv", 32'(snoop_invalidate), 32'((o == 2'b10) ? oth : '0));
        chk("snoop_addr", bus_addr, a);
        chk("snoop_memreq", 32'(mem_req), 32'd0);
        chk("snoop_shared", 32'(shared_hit), 32'd0);
        chk("snoop_done", 32'(done), 32'd0);
        mem_ack = 1'($urandom);
        if (scramble) begin
            req_valid[w]         = 1'b0;
            req_op[2*w +: 2]     = 2'($urandom);
            req_addr[AW*w +: AW] = $urandom;
        end
        step();
        mem_ack = 1'b0;
        if (dt) begin
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
                chk("wb_req", {30'd0, mem_req, mem_we}, 32'd3);
                chk("wb_gnt", 32'(gnt), 32'(onehot(w)));
                chk("wb_shared", 32'(shared_hit), 32'(exp_sh));
                chk("wb_done", 32'(done), 32'd0);
                chk("wb_addr", bus_addr, a);
                mem_ack = (c == lat);
                step();
                mem_ack = 1'b0;
            end
        end
        if (o != 2'b10) begin
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
                chk("mem_req", {30'd0, mem_req, mem_we}, 32'd2);
                chk("mem_gnt", 32'(gnt), 32'(onehot(w)));
                chk("mem_shared", 32'(shared_hit), 32'(exp_sh));
                chk("mem_done", 32'(done), 32'd0);
                mem_ack = (c == lat);
                step();
                mem_ack = 1'b0;
            end
        end
        chk("done_pulse", 32'(done), 32'(onehot(w)));
        chk("done_gnt", 32'(gnt), 32'(onehot(w)));
        chk("done_shared", 32'(shared_hit), 32'(exp_sh));
        chk("done_memreq", 32'(mem_req), 32'd0);
        chk("done_snoops", 32'(snoop_read | snoop_read_excl | snoop_invalidate), 32'd0);
        if (!keep) req_valid[w] = 1'b0;
        step();
        chk_idle("post");
        rr = (w + 1) % N;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_op      = '0;
        req_addr    = '0;
        cache_state = '0;
        mem_ack     = 1'b0;
        step();
        step();
        chk_idle("reset");
        chk("reset_addr", bus_addr, 32'd0);
        chk("reset_snoops", 32'(snoop_read | snoop_read_excl | snoop_invalidate), 32'd0);
        chk("reset_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        step();
        chk_idle("no_req");

        // Plain BusRd, nobody holds the line
        set_req(0, 2'b00, 32'h1000_0040);
        run_txn(pick(req_valid, rr), 1'b0, 1'b0);

        // BusRd with a sharer in S
        cache_state = 8'b00_01_00_00;
        set_req(1, 2'b00, 32'h2000_0080);
        run_txn(pick(req_valid, rr), 1'b0, 1'b0);

        // BusRdX with a dirty owner: write-back then read
        cache_state = 8'b11_00_00_00;
        set_req(0, 2'b01, 32'h3000_00c0);
        run_txn(pick(req_valid, rr), 1'b0, 1'b0);

        // BusUpgr with clean sharers: no memory traffic
        cache_state = 8'b00_01_01_01;
        set_req(2, 2'b10, 32'h4000_0100);
        run_txn(pick(req_valid, rr), 1'b0, 1'b0);

        // Reset while in MEM abandons the transaction
        cache_state = '0;
        set_req(1, 2'b00, 32'h5000_0140);
        set_req(3, 2'b01, 32'h6000_0180);
        step();
        step();
        chk("pre_rst_memreq", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("mid_rst");
        chk("mid_rst_addr", bus_addr, 32'd0);
        rr = 0;
        run_txn(pick(req_valid, rr), 1'b1, 1'b0);
        req_valid = '0;

        // Fair rotation under continuous contention, starting from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        rr = 0;
        for (int i = 0; i < N; i++) set_req(i, 2'($urandom), $urandom);
        for (int t = 0; t < 5; t++) run_txn(pick(req_valid, rr), 1'b1, 1'b0);
        req_valid = '0;
        step();
        chk_idle("rr_end");

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 2) == 0)) set_req(i, 2'($urandom), $urandom);
            end
            if (req_valid == '0) set_req($urandom_range(0, N - 1), 2'($urandom), $urandom);
            cache_state = 8'($urandom);
            run_txn(pick(req_valid, rr), 1'b0, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
